// File: rtl/avl_slv_pkg.sv
// Shared constants and types for the Avalon-MM burst RAM responder.
// Holds the MCB Avalon width defaults, the FSM state encoding and the beat-counter type.
package avl_slv_pkg;

  // MCB Avalon parameter set defaults
  localparam int unsigned AvlAddrW = 22;
  localparam int unsigned AvlDataW = 32;
  localparam int unsigned AvlBeW   = AvlDataW / 8;

  // Beat counter / burst length width (burstcount is 4 bits)
  localparam int unsigned BeatCntW = 4;

  typedef logic [BeatCntW-1:0] beat_cnt_t;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWrBurst = 2'd1,
    StRdBurst = 2'd2
  } avl_slv_state_e;

  // A zero burstcount is treated as a single beat
  function automatic beat_cnt_t eff_len(input logic [3:0] burstcount);
    return (burstcount == 4'd0) ? beat_cnt_t'(1) : beat_cnt_t'(burstcount);
  endfunction

endpackage

// File: rtl/avl_slv_rd_pipe.sv
// Read latency pipe: Depth-deep valid/data shift register fed by the RAM read port.
// Stage 0 is the synchronous RAM read register; the last stage drives the bus.
// Data stages only advance with a valid beat, so the output holds between beats.
module avl_slv_rd_pipe #(
  parameter int unsigned DataW = 32,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic             last_i,
  input  logic [DataW-1:0] data_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o,
  output logic             last_next_o
);

  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] last_q, last_d;
  logic [DataW-1:0] data_q [Depth];
  logic [DataW-1:0] data_d [Depth];

  logic [Depth-1:0] v_in;
  logic [Depth-1:0] l_in;
  logic [DataW-1:0] d_in [Depth];

  // Shift every stage by one; data is only replaced when a valid beat arrives
  always_comb begin
    v_in[0] = valid_i;
    l_in[0] = valid_i & last_i;
    d_in[0] = data_i;
    for (int k = 1; k < Depth; k++) begin
      v_in[k] = valid_q[k-1];
      l_in[k] = last_q[k-1];
      d_in[k] = data_q[k-1];
    end
    for (int k = 0; k < Depth; k++) begin
      valid_d[k] = v_in[k];
      last_d[k]  = l_in[k];
      data_d[k]  = v_in[k] ? d_in[k] : data_q[k];
    end
  end

  // Pipe registers, cleared by reset so in-flight beats are dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      last_q  <= '0;
      for (int k = 0; k < Depth; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      for (int k = 0; k < Depth; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign data_o  = data_q[Depth-1];

  // Last beat will be presented on the coming edge; registered source only
  if (Depth > 1) begin : g_last_next
    assign last_next_o = last_q[Depth-2];
  end else begin : g_last_next_one
    assign last_next_o = 1'b0;
  end

  // The output stage's last flag is only needed one stage earlier
  logic unused_last;
  assign unused_last = last_q[Depth-1];

endmodule

// File: rtl/avl_burst_ram_slv.sv
// Avalon-MM avs_s1 burst slave backed by a 2^MEM_A_W-word on-chip RAM.
// Fixed read latency RD_LAT (1..8), zero-latency writes with byte enables.
// Optional build macro AVL_SLV_WAIT_INJ_EN: stall one cycle after every 4th write beat.
module avl_burst_ram_slv
  import avl_slv_pkg::*;
#(
  parameter int unsigned AVL_A_W  = AvlAddrW,
  parameter int unsigned AVL_D_W  = AvlDataW,
  parameter int unsigned AVL_BE_W = AvlBeW,
  parameter int unsigned MEM_A_W  = 8,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic                csi_clockreset_clk,
  input  logic                csi_clockreset_reset_n,
  input  logic [AVL_A_W-1:0]  avs_s1_address,
  input  logic                avs_s1_read,
  input  logic                avs_s1_write,
  input  logic                avs_s1_beginbursttransfer,
  input  logic [3:0]          avs_s1_burstcount,
  input  logic [AVL_D_W-1:0]  avs_s1_writedata,
  input  logic [AVL_BE_W-1:0] avs_s1_byteenable,
  output logic                avs_s1_waitrequest,
  output logic                avs_s1_readdatavalid,
  output logic [AVL_D_W-1:0]  avs_s1_readdata
);

  localparam int unsigned MemDepth = 2 ** MEM_A_W;

  avl_slv_state_e     state_q, state_d;
  beat_cnt_t          beat_cnt_q, beat_cnt_d;
  beat_cnt_t          len_q, len_d;
  logic [MEM_A_W-1:0] base_q, base_d;
  logic               wait_q, wait_d;

  beat_cnt_t          cmd_len;
  logic [MEM_A_W-1:0] cmd_idx;
  logic [MEM_A_W-1:0] seq_idx;

  logic               wr_en;
  logic [MEM_A_W-1:0] wr_idx;
  logic               rd_issue;
  logic               rd_last;
  logic [MEM_A_W-1:0] rd_idx;
  logic [AVL_D_W-1:0] rd_data;
  logic               pipe_last_next;
  logic               rd_done;

  logic [AVL_D_W-1:0] mem_q [MemDepth];

  assign cmd_len = eff_len(avs_s1_burstcount);
  assign cmd_idx = avs_s1_address[MEM_A_W-1:0];
  // RAM index wraps modulo the RAM depth
  assign seq_idx = base_q + MEM_A_W'(beat_cnt_q);

  // Burst FSM: command decode, beat sequencing and the registered stall
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    wait_d     = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = seq_idx;
    rd_issue   = 1'b0;
    rd_last    = 1'b0;
    rd_idx     = seq_idx;
    rd_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (avs_s1_beginbursttransfer && !wait_q) begin
          base_d     = cmd_idx;
          len_d      = cmd_len;
          beat_cnt_d = beat_cnt_t'(1);
          // Write wins over a simultaneous read; the command cycle carries beat 0
          if (avs_s1_write) begin
            wr_en  = 1'b1;
            wr_idx = cmd_idx;
            if (cmd_len != beat_cnt_t'(1)) begin
              state_d = StWrBurst;
            end
          end else if (avs_s1_read) begin
            rd_issue = 1'b1;
            rd_idx   = cmd_idx;
            rd_last  = (cmd_len == beat_cnt_t'(1));
            // With a one-cycle pipe a single beat is presented on this very edge
            if (!((RD_LAT == 1) && rd_last)) begin
              state_d = StRdBurst;
              wait_d  = 1'b1;
            end
          end
        end
      end

      StWrBurst: begin
        if (avs_s1_write && !wait_q) begin
          wr_en      = 1'b1;
          beat_cnt_d = beat_cnt_q + beat_cnt_t'(1);
          if (beat_cnt_d == len_q) begin
            state_d = StIdle;
          end
`ifdef AVL_SLV_WAIT_INJ_EN
          // One stall cycle after every 4th accepted beat, including a trailing one
          wait_d = (beat_cnt_d[1:0] == 2'b00);
`endif
        end
      end

      StRdBurst: begin
        wait_d = 1'b1;
        if (beat_cnt_q != len_q) begin
          rd_issue   = 1'b1;
          rd_last    = ((beat_cnt_q + beat_cnt_t'(1)) == len_q);
          beat_cnt_d = beat_cnt_q + beat_cnt_t'(1);
        end
        rd_done = pipe_last_next || ((RD_LAT == 1) && rd_issue && rd_last);
        // Drop the stall on the edge that presents the last beat
        if (rd_done) begin
          state_d = StIdle;
          wait_d  = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
    if (!csi_clockreset_reset_n) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      len_q      <= '0;
      base_q     <= '0;
      wait_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      wait_q     <= wait_d;
    end
  end

  // RAM write port with per-byte enables; contents survive reset
  always_ff @(posedge csi_clockreset_clk) begin
    if (wr_en) begin
      for (int b = 0; b < AVL_BE_W; b++) begin
        if (avs_s1_byteenable[b]) begin
          mem_q[wr_idx][8*b +: 8] <= avs_s1_writedata[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

  avl_slv_rd_pipe #(
    .DataW (AVL_D_W),
    .Depth (RD_LAT)
  ) u_rd_pipe (
    .clk_i       (csi_clockreset_clk),
    .rst_ni      (csi_clockreset_reset_n),
    .valid_i     (rd_issue),
    .last_i      (rd_last),
    .data_i      (rd_data),
    .valid_o     (avs_s1_readdatavalid),
    .data_o      (avs_s1_readdata),
    .last_next_o (pipe_last_next)
  );

  assign avs_s1_waitrequest = wait_q;

  // Upper address bits select nothing in this RAM
  logic unused_addr;
  assign unused_addr = ^avs_s1_address[AVL_A_W-1:MEM_A_W];

endmodule

// File: tb/tb_avl_burst_ram_slv.sv
// Self-checking bench for avl_burst_ram_slv: directed protocol cases plus random
// bursts checked against an array memory model and a per-cycle read-beat schedule.
module tb_avl_burst_ram_slv;

  localparam int unsigned AW       = 22;
  localparam int unsigned DW       = 32;
  localparam int unsigned BEW      = 4;
  localparam int unsigned MAW      = 8;
  localparam int unsigned RdLat    = 2;
  localparam int unsigned MemWords = 1 << MAW;
`ifdef AVL_SLV_WAIT_INJ_EN
  localparam bit InjEn = 1'b1;
`else
  localparam bit InjEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [AW-1:0]  address = '0;
  logic           read = 1'b0;
  logic           write = 1'b0;
  logic           bbt = 1'b0;
  logic [3:0]     burstcount = '0;
  logic [DW-1:0]  writedata = '0;
  logic [BEW-1:0] byteenable = '0;
  logic           wreq;
  logic           rdv;
  logic [DW-1:0]  rdata;

  avl_burst_ram_slv #(
    .AVL_A_W  (AW),
    .AVL_D_W  (DW),
    .AVL_BE_W (BEW),
    .MEM_A_W  (MAW),
    .RD_LAT   (RdLat)
  ) dut (
    .csi_clockreset_clk        (clk),
    .csi_clockreset_reset_n    (rst_n),
    .avs_s1_address            (address),
    .avs_s1_read               (read),
    .avs_s1_write              (write),
    .avs_s1_beginbursttransfer (bbt),
    .avs_s1_burstcount         (burstcount),
    .avs_s1_writedata          (writedata),
    .avs_s1_byteenable         (byteenable),
    .avs_s1_waitrequest        (wreq),
    .avs_s1_readdatavalid      (rdv),
    .avs_s1_readdata           (rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } beat_t;

  logic [DW-1:0]  ref_mem [MemWords];
  beat_t          exp_q [$];
  logic [DW-1:0]  last_rd = '0;
  logic [DW-1:0]  wbuf  [16];
  logic [BEW-1:0] bebuf [16];

  int unsigned pat_a [4] = '{4, 5, 7, 9};
  int unsigned pat_b [8] = '{1, 3, 1, 7, 6, 2, 0, 8};
  int unsigned pat_c [8] = '{0, 7, 4, 8, 5, 3, 3, 2};

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic void model_write(input int idx, input logic [DW-1:0] d,
                                      input logic [BEW-1:0] be);
    for (int b = 0; b < BEW; b++) begin
      if (be[b]) ref_mem[idx % MemWords][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  // Every cycle: a beat must appear exactly when scheduled, with model data
  bit    due;
  beat_t mb;
  always @(negedge clk) begin
    if (rst_n) begin
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check_eq("rdv_schedule", {31'b0, rdv}, {31'b0, due});
      if (due) begin
        mb = exp_q.pop_front();
        if (rdv) begin
          check_eq("rdata", rdata, mb.data);
          last_rd = mb.data;
        end
      end else if (!rdv) begin
        check_eq("rdata_hold", rdata, last_rd);
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (wreq && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    if (wreq) check_eq("ready_timeout", {31'b0, wreq}, 32'd0);
  endtask

  task automatic rand_wbuf(input bit rand_be);
    for (int i = 0; i < 16; i++) begin
      wbuf[i]  = $urandom();
      bebuf[i] = rand_be ? BEW'($urandom_range(0, 15)) : '1;
    end
  endtask

  task automatic wr_burst(input logic [AW-1:0] addr, input logic [3:0] bc, input bit with_read,
                          input bit bubbles);
    int n, acc, g, base;
    bit take;
    n    = (bc == 0) ? 1 : int'(bc);
    base = int'(addr[MAW-1:0]);
    wait_ready();
    address    = addr;
    bbt        = 1'b1;
    write      = 1'b1;
    read       = with_read;
    burstcount = bc;
    writedata  = wbuf[0];
    byteenable = bebuf[0];
    @(posedge clk);
    model_write(base, wbuf[0], bebuf[0]);
    acc = 1;
    #1;
    bbt  = 1'b0;
    read = 1'b0;
    check_eq("wr_wait", {31'b0, wreq}, {31'b0, InjEn && (acc % 4 == 0)});
    g = 0;
    while (acc < n && g < 200) begin
      writedata  = wbuf[acc];
      byteenable = bebuf[acc];
      write      = !bubbles || ($urandom_range(0, 3) != 0);
      take       = write && !wreq;
      @(posedge clk);
      if (take) begin
        model_write(base + acc, wbuf[acc], bebuf[acc]);
        acc++;
      end
      #1;
      check_eq("wr_wait", {31'b0, wreq}, {31'b0, InjEn && take && (acc % 4 == 0)});
      g++;
    end
    write = 1'b0;
    if (acc < n) check_eq("wr_timeout", acc, n);
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input logic [3:0] bc, input bit hold);
    int n, t0, fall, g;
    beat_t b;
    n = (bc == 0) ? 1 : int'(bc);
    wait_ready();
    address    = addr;
    bbt        = 1'b1;
    read       = 1'b1;
    write      = 1'b0;
    burstcount = bc;
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      b.data = ref_mem[(int'(addr[MAW-1:0]) + i) % MemWords];
      b.cyc  = t0 + RdLat - 1 + i;
      exp_q.push_back(b);
    end
    bbt  = 1'b0;
    read = hold;
    fall = t0 + RdLat - 2 + n;
    check_eq("rd_wait_rise", {31'b0, wreq}, {31'b0, fall != t0});
    g = 0;
    while (wreq && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("rd_wait_fall", cyc, fall);
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
    end
    read = 1'b0;
  endtask

  task automatic rd_reset_mid();
    int t0;
    beat_t b;
    wait_ready();
    address    = 72;
    bbt        = 1'b1;
    read       = 1'b1;
    burstcount = 4'd8;
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      b.data = ref_mem[(72 + i) % MemWords];
      b.cyc  = t0 + RdLat - 1 + i;
      exp_q.push_back(b);
    end
    bbt  = 1'b0;
    read = 1'b0;
    while (cyc < t0 + RdLat + 1) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    last_rd = '0;
    #1;
    check_eq("rst_rdv", {31'b0, rdv}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_wait", {31'b0, wreq}, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("rst_rdv_stays", {31'b0, rdv}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    check_eq("reset_wait", {31'b0, wreq}, 32'd0);
    check_eq("reset_rdv", {31'b0, rdv}, 32'd0);
    check_eq("reset_rdata", rdata, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Make every RAM word known (last burst wraps past the top)
    for (int a = 0; a < int'(MemWords); a += 15) begin
      rand_wbuf(1'b0);
      wr_burst(AW'(a), 4'd15, 1'b0, 1'b0);
    end

    // Write 4 then 8, read 8 across both
    for (int i = 0; i < 4; i++) begin wbuf[i] = pat_a[i]; bebuf[i] = '1; end
    wr_burst(22'd72, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin wbuf[i] = pat_b[i]; bebuf[i] = '1; end
    wr_burst(22'd76, 4'd8, 1'b0, 1'b0);
    rd_burst(22'd72, 4'd8, 1'b0);

    // Wrap-around at the top of the RAM, with upper address bits set
    for (int i = 0; i < 8; i++) begin wbuf[i] = pat_c[i]; bebuf[i] = '1; end
    wr_burst(22'h3F_00FE, 4'd8, 1'b0, 1'b0);
    rd_burst(22'd254, 4'd8, 1'b0);
    rd_burst(22'd0, 4'd4, 1'b0);

    // Byte enables
    wbuf[0] = 32'hAABBCCDD; bebuf[0] = 4'hF;
    wr_burst(22'd10, 4'd1, 1'b0, 1'b0);
    wbuf[0] = 32'h11223344; bebuf[0] = 4'b0101;
    wr_burst(22'd10, 4'd1, 1'b0, 1'b0);
    rd_burst(22'd10, 4'd1, 1'b0);

    // Read held high after acceptance, read+write command, burstcount 0
    rd_burst(22'd100, 4'd4, 1'b1);
    rand_wbuf(1'b0);
    wr_burst(22'd120, 4'd3, 1'b1, 1'b0);
    rd_burst(22'd120, 4'd3, 1'b0);
    rand_wbuf(1'b0);
    wr_burst(22'd130, 4'd0, 1'b0, 1'b0);
    rd_burst(22'd130, 4'd0, 1'b0);

    // Reset in the middle of a read, then read again
    rd_reset_mid();
    rd_burst(22'd72, 4'd8, 1'b0);

    // Random traffic
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        rand_wbuf(1'b1);
        wr_burst(AW'($urandom()), 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, 1'b1);
      end else begin
        rd_burst(AW'($urandom()), 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check_eq("exp_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/avl_burst_ram_slv.md
# avl_burst_ram_slv

Synthesizable Avalon-MM burst responder backed by on-chip RAM, speaking the slave side of the `avs_s1` burst protocol the MCB exposes. It is a drop-in stand-in for `MCB_AVL_IP_TOP`: masters, DMA engines and burst tasks are exercised against a zero-refresh, fixed-latency memory with identical handshake rules. It sits wherever an `avs_s1` slave is expected and shares the MCB Avalon parameter set.

## Interface
Clock `csi_clockreset_clk`; reset `csi_clockreset_reset_n` is asynchronous and active-low.

Parameters:
- `AVL_A_W`, 22: Avalon word-address width.
- `AVL_D_W`, 32: data width.
- `AVL_BE_W`, 4: byte-enable width (`AVL_D_W/8`).
- `MEM_A_W`, 8: RAM depth is 2^MEM_A_W words.
- `RD_LAT`, 2: cycles from read-command acceptance to the first `readdatavalid`. Range 1..8.

Ports:
- `csi_clockreset_clk` in 1: clock.
- `csi_clockreset_reset_n` in 1: async active-low reset.
- `avs_s1_address` in AVL_A_W: burst start word address.
- `avs_s1_read` in 1: read request.
- `avs_s1_write` in 1: write request, qualifies each write beat.
- `avs_s1_beginbursttransfer` in 1: marks the command cycle.
- `avs_s1_burstcount` in 4: burst length in beats.
- `avs_s1_writedata` in AVL_D_W: write beat data.
- `avs_s1_byteenable` in AVL_BE_W: per-byte write mask.
- `avs_s1_waitrequest` out 1: registered stall.
- `avs_s1_readdatavalid` out 1: read beat valid.
- `avs_s1_readdata` out AVL_D_W: read beat data.

## Operation
- **States:** IDLE, WR_BURST, RD_BURST.
- **Commands** are recognised only in IDLE, in a cycle where `beginbursttransfer`=1 and `waitrequest`=0. `read`/`write` without `beginbursttransfer` in IDLE are ignored, since masters hold `read` high after acceptance.
- **Burst length:** `len` = burstcount. burstcount=0 is treated as 1.
- **Simultaneous `read` and `write`** in the command cycle: the write wins and the read is dropped.
- **Addressing:** the RAM index is `address[MEM_A_W-1:0] + beat`, taken modulo 2^MEM_A_W (wraps silently). Upper address bits are ignored.
- **Write path:**
  - The command cycle also carries beat 0.
  - Each subsequent cycle with `write`=1 and `waitrequest`=0 accepts one beat.
  - Bytes are written only where `byteenable`=1.
  - After `len` beats, return to IDLE. The last beat accepted in the command cycle (len=1) means the state stays IDLE.
  - `write`=0 during WR_BURST is a bubble: nothing is written and the beat counter holds.
- **Read path:**
  - On acceptance, go to RD_BURST and set `waitrequest`=1.
  - Issue `len` consecutive RAM reads through the latency pipe.
  - Return to IDLE when the last beat is presented.
- **Reset** (any time, including mid-burst):
  - State goes to IDLE; the beat counter and latency pipe are cleared.
  - In-flight read beats are discarded.
  - RAM contents are retained, and are undefined after power-up.

## Timing
- **Reset values:** `waitrequest`=0, `readdatavalid`=0, `readdata`=0.
- **Write:** beats are accepted with zero-cycle latency, and a written word is readable by a command accepted on the next edge. `waitrequest`=0 throughout, unless `AVL_SLV_WAIT_INJ_EN` is defined.
- **Read:**
  - Command accepted at edge T0.
  - `readdatavalid`=1 with beat i on the cycle following edge T0+RD_LAT-1+i, for i=0..len-1, with no gaps.
  - `waitrequest` rises at T0 and falls at the edge presenting the last beat, so the next command is accepted on the following edge.
- **`readdata`** holds its last value while `readdatavalid`=0.

## Configuration
- **`AVL_SLV_WAIT_INJ_EN` defined:** during WR_BURST, `waitrequest` is registered high for exactly one cycle after every 4th accepted write beat (counted from beat 0). Beats offered while it is high are not accepted and must be held by the master.
- **Undefined:** write beats never stall.
- Reads are unaffected either way.

## Structure
- **Shared include/package `avl_slv_pkg`:**
  - The state encoding (IDLE=0, WR_BURST=1, RD_BURST=2).
  - A beat-counter width of 4.
  - Reuses the `AVL_*_W` constants already in the MCB Avalon parameter file.
- **One sub-module, `avl_slv_rd_pipe`:** RD_LAT-deep valid/data shift register fed by a synchronous RAM read. It is reset-clearable and separates the latency logic from the FSM.

## Test plan
- **Write 4 then read 8:** write 4 beats at 72 (4,5,7,9), write 8 at 76 (1,3,1,7,6,2,0,8), read 8 at 72 → readdata 4,5,7,9,1,3,1,7 on 8 consecutive valid cycles, first at RD_LAT after acceptance.
- **Wrap-around:** write 8 at 254 (0,7,4,8,5,3,3,2), read 8 at 254 → same data. A read of 4 at 0 → 4,8,5,3.
- **Byte-enable:** write 0xAABBCCDD to word 10, then write 0x11223344 with byteenable=4'b0101 → read returns 0xAA22CC44.
- **Protocol edges:**
  - Read with `read` held high after acceptance → exactly one burst.
  - Read+write in the same command cycle → only the write executes.
  - burstcount=0 → one beat.
- **Reset mid-read:** assert reset after 3 of 8 beats → `readdatavalid` is 0 immediately and stays 0. A new read after reset returns the correct data.
- **With `AVL_SLV_WAIT_INJ_EN`:** 8-beat write → `waitrequest` high for one cycle after beats 4 and 8. All 8 words are stored correctly, and the total burst takes 9 cycles plus the trailing stall.
